// File: rtl/ysyx_23060136_axi_rd_arbiter.sv
// ysyx_23060136_axi_rd_arbiter
// N-client AXI4 read arbiter. Merges per-client read requests onto one AXI
// AR/R channel, using fixed-priority or round-robin grant. Each burst is
// streamed beat-by-beat to the granted client, with per-beat and sticky error
// reporting.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   req_valid/ready/addr/size/len  per-client request (client i at slice i)
//   rsp_valid/ready             per-client beat handshake
//   rsp_data/last/err           shared beat payload, last flag, beat error
//   io_master_ar*               AXI read-address channel
//   io_master_r*                AXI read-data channel
//   busy                        FSM not idle
//   err_sticky                  any beat error or stray beat since reset
module ysyx_23060136_axi_rd_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int ARB_MODE    = 0,
  parameter int ARID        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*3-1:0]      req_size,
  input  logic [NUM_CLIENTS*8-1:0]      req_len,
  output logic [NUM_CLIENTS-1:0]        rsp_valid,
  input  logic [NUM_CLIENTS-1:0]        rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_last,
  output logic                          rsp_err,
  output logic                          io_master_arvalid,
  input  logic                          io_master_arready,
  output logic [31:0]                   io_master_araddr,
  output logic [3:0]                    io_master_arid,
  output logic [7:0]                    io_master_arlen,
  output logic [2:0]                    io_master_arsize,
  output logic [1:0]                    io_master_arburst,
  input  logic                          io_master_rvalid,
  output logic                          io_master_rready,
  input  logic [63:0]                   io_master_rdata,
  input  logic [1:0]                    io_master_rresp,
  input  logic                          io_master_rlast,
  input  logic [3:0]                    io_master_rid,
  output logic                          busy,
  output logic                          err_sticky
);

  localparam int unsigned N     = NUM_CLIENTS;
  localparam int          IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [3:0]  C_ARID = 4'(ARID);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_last;
  logic [ADDR_W-1:0]  r_addr;
  logic [2:0]         r_size;
  logic [7:0]         r_len;
  logic [7:0]         r_cnt;
  logic               r_err_sticky;

  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic               w_req_hs;
  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_stray;
  logic               w_len_hit;

  // Winner selection. Round-robin searches upward from the slot after the
  // most recent grant, wrapping modulo N.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!w_any && req_valid[i]) begin
          w_any = 1'b1;
          w_win = IDX_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        if (!w_any && req_valid[(32'(r_last) + k) % N]) begin
          w_any = 1'b1;
          w_win = IDX_W'((32'(r_last) + k) % N);
        end
      end
    end
  end

  always_comb begin
    w_next            = r_state;
    req_ready         = '0;
    rsp_valid         = '0;
    rsp_data          = '0;
    rsp_last          = 1'b0;
    rsp_err           = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    w_req_hs          = 1'b0;
    w_ar_hs           = 1'b0;
    w_r_hs            = 1'b0;
    w_stray           = 1'b0;
    w_len_hit         = (r_cnt == r_len);
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready[w_win] = 1'b1;
          w_req_hs         = 1'b1;
          w_next           = S_ADDR;
        end
        // Beats arriving with no burst outstanding are drained and flagged.
        io_master_rready = io_master_rvalid;
        w_stray          = io_master_rvalid;
      end
      S_ADDR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) begin
          w_ar_hs = 1'b1;
          w_next  = S_DATA;
        end
      end
      S_DATA: begin
        rsp_valid[r_gnt] = io_master_rvalid;
        io_master_rready = rsp_ready[r_gnt];
        rsp_data         = DATA_W'(io_master_rdata);
        if (io_master_rvalid) begin
          // rlast disagreeing with the beat count covers both early and
          // missing last; a missing last is forced so the client terminates.
          rsp_err  = (io_master_rresp != 2'b00) || (io_master_rid != C_ARID) ||
                     (io_master_rlast != w_len_hit);
          rsp_last = io_master_rlast || w_len_hit;
        end
        w_r_hs = io_master_rvalid && rsp_ready[r_gnt];
        if (w_r_hs && (io_master_rlast || w_len_hit)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_last       <= IDX_W'(NUM_CLIENTS - 1);
      r_addr       <= '0;
      r_size       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_req_hs) begin
        r_gnt  <= w_win;
        r_last <= w_win;
        r_addr <= req_addr[w_win*ADDR_W +: ADDR_W];
        r_size <= req_size[w_win*3 +: 3];
        r_len  <= req_len[w_win*8 +: 8];
      end
      if (w_ar_hs) begin
        r_cnt <= '0;
      end else if (w_r_hs) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (rsp_err || w_stray) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  assign io_master_araddr  = 32'(r_addr);
  assign io_master_arid    = C_ARID;
  assign io_master_arlen   = r_len;
  assign io_master_arsize  = r_size;
  assign io_master_arburst = 2'b01;
  assign busy              = (r_state != S_IDLE);
  assign err_sticky        = r_err_sticky;

endmodule

// File: tb/tb_ysyx_23060136_axi_rd_arbiter.sv
module tb_ysyx_23060136_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fixed-priority, 2 clients
  logic [1:0]   f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [63:0]  f_req_addr;
  logic [5:0]   f_req_size;
  logic [15:0]  f_req_len;
  logic [63:0]  f_rsp_data, f_rdata;
  logic         f_rsp_last, f_rsp_err, f_arvalid, f_arready, f_rvalid, f_rready, f_rlast;
  logic [31:0]  f_araddr;
  logic [3:0]   f_arid, f_rid;
  logic [7:0]   f_arlen;
  logic [2:0]   f_arsize;
  logic [1:0]   f_arburst, f_rresp;
  logic         f_busy, f_err;

  ysyx_23060136_axi_rd_arbiter #(.NUM_CLIENTS(2), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_addr(f_req_addr),
    .req_size(f_req_size), .req_len(f_req_len),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data),
    .rsp_last(f_rsp_last), .rsp_err(f_rsp_err),
    .io_master_arvalid(f_arvalid), .io_master_arready(f_arready),
    .io_master_araddr(f_araddr), .io_master_arid(f_arid), .io_master_arlen(f_arlen),
    .io_master_arsize(f_arsize), .io_master_arburst(f_arburst),
    .io_master_rvalid(f_rvalid), .io_master_rready(f_rready), .io_master_rdata(f_rdata),
    .io_master_rresp(f_rresp), .io_master_rlast(f_rlast), .io_master_rid(f_rid),
    .busy(f_busy), .err_sticky(f_err)
  );

  // Round-robin, 4 clients
  logic [3:0]   d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
  logic [127:0] d_req_addr;
  logic [11:0]  d_req_size;
  logic [31:0]  d_req_len;
  logic [63:0]  d_rsp_data, d_rdata;
  logic         d_rsp_last, d_rsp_err, d_arvalid, d_arready, d_rvalid, d_rready, d_rlast;
  logic [31:0]  d_araddr;
  logic [3:0]   d_arid, d_rid;
  logic [7:0]   d_arlen;
  logic [2:0]   d_arsize;
  logic [1:0]   d_arburst, d_rresp;
  logic         d_busy, d_err;

  ysyx_23060136_axi_rd_arbiter #(.NUM_CLIENTS(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_addr(d_req_addr),
    .req_size(d_req_size), .req_len(d_req_len),
    .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_data(d_rsp_data),
    .rsp_last(d_rsp_last), .rsp_err(d_rsp_err),
    .io_master_arvalid(d_arvalid), .io_master_arready(d_arready),
    .io_master_araddr(d_araddr), .io_master_arid(d_arid), .io_master_arlen(d_arlen),
    .io_master_arsize(d_arsize), .io_master_arburst(d_arburst),
    .io_master_rvalid(d_rvalid), .io_master_rready(d_rready), .io_master_rdata(d_rdata),
    .io_master_rresp(d_rresp), .io_master_rlast(d_rlast), .io_master_rid(d_rid),
    .busy(d_busy), .err_sticky(d_err)
  );

  // Single-beat transaction on the round-robin instance; request already driven.
  task automatic d_single(input int g);
    #1 chk("rr_grant", 64'(d_req_ready), 64'(1) << g);
    @(posedge clk); @(negedge clk);
    #1 chk("rr_araddr", 64'(d_araddr), 64'(32'h1000 * g));
    d_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    d_arready = 1'b0;
    d_rvalid = 1'b1; d_rlast = 1'b1; d_rdata = 64'hD0 + 64'(g);
    #1 chk("rr_rsp_valid", 64'(d_rsp_valid), 64'(1) << g);
    @(posedge clk); @(negedge clk);
    d_rvalid = 1'b0; d_rlast = 1'b0;
  endtask

  // Multi-beat burst on the round-robin instance with per-beat expected masks.
  task automatic d_burst(input int g, input logic [7:0] len, input int nbeats,
                         input int rresp_beat, input int rlast_beat, input int stall_beat,
                         input logic [7:0] exp_err, input logic [7:0] exp_last);
    d_req_valid = 4'(1 << g);
    d_req_len[g*8 +: 8] = len;
    d_req_size[g*3 +: 3] = 3'd3;
    #1 chk("burst_grant", 64'(d_req_ready), 64'(1) << g);
    @(posedge clk); @(negedge clk);
    d_req_valid = '0;
    #1;
    chk("burst_arvalid", 64'(d_arvalid), 64'd1);
    chk("burst_arlen", 64'(d_arlen), 64'(len));
    chk("burst_arsize", 64'(d_arsize), 64'd3);
    chk("burst_arburst", 64'(d_arburst), 64'd1);
    d_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    d_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d_rvalid = 1'b1;
      d_rdata  = 64'hA000 + 64'(g * 16 + b);
      d_rresp  = (b == rresp_beat) ? 2'b10 : 2'b00;
      d_rlast  = (b == rlast_beat);
      if (b == stall_beat) begin
        d_rsp_ready = '0;
        repeat (5) begin
          #1;
          chk("stall_rready", 64'(d_rready), 64'd0);
          chk("stall_data", d_rsp_data, 64'hA000 + 64'(g * 16 + b));
          @(posedge clk); @(negedge clk);
        end
        d_rsp_ready = '1;
      end
      #1;
      chk("beat_valid", 64'(d_rsp_valid), 64'(1) << g);
      chk("beat_data", d_rsp_data, 64'hA000 + 64'(g * 16 + b));
      chk("beat_err", 64'(d_rsp_err), 64'(exp_err[b]));
      chk("beat_last", 64'(d_rsp_last), 64'(exp_last[b]));
      chk("beat_rready", 64'(d_rready), 64'd1);
      @(posedge clk); @(negedge clk);
    end
    d_rvalid = 1'b0; d_rlast = 1'b0; d_rresp = 2'b00;
    #1 chk("burst_idle", 64'(d_busy), 64'd0);
  endtask

  initial begin
    f_req_valid = '0; f_rsp_ready = '1; f_arready = 1'b0; f_rvalid = 1'b0;
    f_rdata = '0; f_rresp = '0; f_rlast = 1'b0; f_rid = '0;
    f_req_addr = {32'h8000_0010, 32'h8000_0000}; f_req_size = {3'd2, 3'd2}; f_req_len = '0;
    d_req_valid = '0; d_rsp_ready = '1; d_arready = 1'b0; d_rvalid = 1'b0;
    d_rdata = '0; d_rresp = '0; d_rlast = 1'b0; d_rid = '0;
    d_req_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0}; d_req_size = '0; d_req_len = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(d_req_ready), 64'd0);
    chk("rst_arvalid", 64'(d_arvalid), 64'd0);
    chk("rst_busy", 64'(d_busy), 64'd0);
    chk("rst_sticky", 64'(d_err), 64'd0);
    chk("rst_rready", 64'(d_rready), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fixed priority: simultaneous requests, client 0 first
    f_req_valid = 2'b11;
    #1 chk("fix_grant0", 64'(f_req_ready), 64'b01);
    @(posedge clk); @(negedge clk);
    f_req_valid = 2'b10;
    #1;
    chk("fix_arvalid", 64'(f_arvalid), 64'd1);
    chk("fix_araddr0", 64'(f_araddr), 64'h8000_0000);
    chk("fix_arlen0", 64'(f_arlen), 64'd0);
    chk("fix_ready_busy", 64'(f_req_ready), 64'd0);
    f_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    f_arready = 1'b0;
    f_rvalid = 1'b1; f_rlast = 1'b1; f_rdata = 64'h1111;
    #1;
    chk("fix_rsp_valid0", 64'(f_rsp_valid), 64'b01);
    chk("fix_rsp_last0", 64'(f_rsp_last), 64'd1);
    chk("fix_rsp_err0", 64'(f_rsp_err), 64'd0);
    chk("fix_rsp_data0", f_rsp_data, 64'h1111);
    @(posedge clk); @(negedge clk);
    f_rvalid = 1'b0; f_rlast = 1'b0;
    #1 chk("fix_grant1", 64'(f_req_ready), 64'b10);
    @(posedge clk); @(negedge clk);
    f_req_valid = 2'b00;
    #1 chk("fix_araddr1", 64'(f_araddr), 64'h8000_0010);
    f_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    f_arready = 1'b0;
    f_rvalid = 1'b1; f_rlast = 1'b1;
    #1 chk("fix_rsp_valid1", 64'(f_rsp_valid), 64'b10);
    @(posedge clk); @(negedge clk);
    f_rvalid = 1'b0; f_rlast = 1'b0;
    #1 chk("fix_idle", 64'(f_busy), 64'd0);

    // Round-robin with all clients requesting: 0,1,2,3,0
    d_req_valid = 4'hF;
    d_single(0);
    d_single(1);
    d_single(2);
    d_single(3);
    d_single(0);
    d_req_valid = '0;

    // Burst of 4 to client 1 with a 5-cycle stall on beat 2
    d_burst(1, 8'd3, 4, -1, 3, 1, 8'b0000, 8'b1000);
    chk("sticky_clean", 64'(d_err), 64'd0);
    // SLVERR on beat 2
    d_burst(2, 8'd2, 3, 1, 2, -1, 8'b0010, 8'b0100);
    chk("sticky_set", 64'(d_err), 64'd1);
    // Early last: len=1 but rlast on first beat
    d_burst(3, 8'd1, 1, -1, 0, -1, 8'b0001, 8'b0001);
    // Missing last: len=0, rlast never asserted; arbiter forces last
    d_burst(0, 8'd0, 1, -1, -1, -1, 8'b0001, 8'b0001);

    // Stray beat in IDLE is absorbed
    d_rvalid = 1'b1;
    #1;
    chk("stray_rready", 64'(d_rready), 64'd1);
    chk("stray_rsp_valid", 64'(d_rsp_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    d_rvalid = 1'b0;

    // Reset during DATA
    d_req_valid = 4'b0011;
    #1 chk("pre_rst_grant", 64'(d_req_ready), 64'b0010);
    @(posedge clk); @(negedge clk);
    d_req_valid = '0;
    d_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    d_arready = 1'b0;
    d_rvalid = 1'b1; d_rdata = 64'h55;
    #1 chk("pre_rst_rsp_valid", 64'(d_rsp_valid), 64'b0010);
    rst = 1'b0; d_rvalid = 1'b0;
    #1;
    chk("arst_busy", 64'(d_busy), 64'd0);
    chk("arst_rsp_valid", 64'(d_rsp_valid), 64'd0);
    chk("arst_rsp_data", d_rsp_data, 64'd0);
    chk("arst_rsp_last", 64'(d_rsp_last), 64'd0);
    chk("arst_rsp_err", 64'(d_rsp_err), 64'd0);
    chk("arst_arvalid", 64'(d_arvalid), 64'd0);
    chk("arst_araddr", 64'(d_araddr), 64'd0);
    chk("arst_arlen", 64'(d_arlen), 64'd0);
    chk("arst_arsize", 64'(d_arsize), 64'd0);
    chk("arst_rready", 64'(d_rready), 64'd0);
    chk("arst_sticky", 64'(d_err), 64'd0);
    chk("arst_req_ready", 64'(d_req_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    d_req_valid = 4'b0011;
    #1 chk("post_rst_grant", 64'(d_req_ready), 64'b0001);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
